// File: rtl/sci_slave.sv
// rtl/sci_slave.sv - serial control interface slave bridging a bit-serial frame to a local register port.
// SCI_SOUT/SCI_SACK share a bus with other slaves, so they float except in ACK and TX_DATA.
module sci_slave #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  SCI_CSN,
  input  logic                  SCI_SIN,
  output logic                  SCI_SOUT,
  output logic                  SCI_SACK,
  output logic [ADDR_WIDTH-1:0] REG_ADDR,
  output logic [DATA_WIDTH-1:0] REG_WDATA,
  output logic                  REG_WE,
  output logic                  REG_RE,
  input  logic [DATA_WIDTH-1:0] REG_RDATA
);

  localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = $clog2(MAX_W);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [3:0] {
    IDLE, RX_ADDR, RX_DATA, WRITE, READ, CAPTURE, ACK, TX_DATA, DONE
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    cnt_zero;
  logic                    wnr;
  logic [ADDR_WIDTH-1:0]   addr_sr, addr_shift;
  logic [DATA_WIDTH-1:0]   data_sr, data_shift;
  logic [DATA_WIDTH-1:0]   tx_sr;
  logic                    bus_drive;

  assign cnt_zero   = (cnt == '0);
  assign addr_shift = (addr_sr << 1) | ADDR_WIDTH'(SCI_SIN);
  assign data_shift = {data_sr[DATA_WIDTH-2:0], SCI_SIN};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state != IDLE && SCI_CSN) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!SCI_CSN) begin
            state_nxt = RX_ADDR;
            cnt_nxt   = ADDR_LAST;
          end
        end
        RX_ADDR: begin
          if (cnt_zero) begin
            if (wnr) begin
              state_nxt = RX_DATA;
              cnt_nxt   = DATA_LAST;
            end else begin
              state_nxt = READ;
            end
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_zero) state_nxt = WRITE;
          else          cnt_nxt   = cnt - 1'b1;
        end
        WRITE:   state_nxt = ACK;
        READ:    state_nxt = CAPTURE;
        CAPTURE: state_nxt = ACK;
        ACK: begin
          if (wnr) begin
            state_nxt = DONE;
          end else begin
            state_nxt = TX_DATA;
            cnt_nxt   = DATA_LAST;
          end
        end
        TX_DATA: begin
          if (cnt_zero) state_nxt = DONE;
          else          cnt_nxt   = cnt - 1'b1;
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Register-side address/data only update on a completed phase, so aborted frames leave them untouched.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state     <= IDLE;
      cnt       <= '0;
      wnr       <= 1'b0;
      addr_sr   <= '0;
      data_sr   <= '0;
      tx_sr     <= '0;
      REG_ADDR  <= '0;
      REG_WDATA <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!SCI_CSN) begin
        case (state)
          IDLE: wnr <= SCI_SIN;
          RX_ADDR: begin
            addr_sr <= addr_shift;
            if (cnt_zero && !wnr) REG_ADDR <= addr_shift;
          end
          RX_DATA: begin
            data_sr <= data_shift;
            if (cnt_zero) begin
              REG_ADDR  <= addr_sr;
              REG_WDATA <= data_shift;
            end
          end
          CAPTURE: tx_sr <= REG_RDATA;
          TX_DATA: tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
          default: ;
        endcase
      end
    end
  end

  assign REG_WE    = (state == WRITE);
  assign REG_RE    = (state == READ);
  assign bus_drive = (state == ACK) || (state == TX_DATA);
  assign SCI_SACK  = bus_drive ? (state == ACK) : 1'bz;
  assign SCI_SOUT  = bus_drive ? ((state == TX_DATA) && tx_sr[DATA_WIDTH-1]) : 1'bz;

endmodule

// File: tb/tb_sci_slave.sv
// tb/tb_sci_slave.sv - self-checking bench for sci_slave with a register-bank model and write/read scoreboards.
// Shared lines are pulled up, so a floating SCI_SOUT/SCI_SACK reads as 1.
module tb_sci_slave;

  localparam logic FLOAT = 1'b1;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        SCI_CSN;
  logic        SCI_SIN;
  wire         SCI_SOUT;
  wire         SCI_SACK;
  logic [4:0]  REG_ADDR;
  logic [31:0] REG_WDATA;
  logic        REG_WE;
  logic        REG_RE;
  logic [31:0] REG_RDATA;

  pullup (SCI_SOUT);
  pullup (SCI_SACK);

  sci_slave #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .CLK(CLK), .RSTN(RSTN), .SCI_CSN(SCI_CSN), .SCI_SIN(SCI_SIN),
    .SCI_SOUT(SCI_SOUT), .SCI_SACK(SCI_SACK),
    .REG_ADDR(REG_ADDR), .REG_WDATA(REG_WDATA),
    .REG_WE(REG_WE), .REG_RE(REG_RE), .REG_RDATA(REG_RDATA)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [4:0] addr; logic [31:0] data; } wr_t;
  wr_t         wr_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] bank [0:31];
  int total = 0;
  int bad   = 0;
  int we_cnt = 0;
  int re_cnt = 0;

  // Register bank and write scoreboard; read data is presented while REG_RE is still high.
  always @(negedge CLK) begin
    wr_t e;
    if (REG_WE === 1'b1) begin
      we_cnt++;
      total++;
      if (wr_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_we got addr=%h data=%h want no strobe", REG_ADDR, REG_WDATA);
      end else begin
        e = wr_q.pop_front();
        if (REG_ADDR !== e.addr || REG_WDATA !== e.data || REG_RE !== 1'b0) begin
          bad++;
          $display("FAIL we_content got addr=%h data=%h re=%b want addr=%h data=%h re=0",
                   REG_ADDR, REG_WDATA, REG_RE, e.addr, e.data);
        end
      end
      bank[REG_ADDR] = REG_WDATA;
    end
    if (REG_RE === 1'b1) begin
      re_cnt++;
      REG_RDATA = bank[REG_ADDR];
    end
  end

  task automatic drive_frame(input logic wnr, input logic [4:0] a, input logic [31:0] d, input int nbits);
    logic [37:0] bits;
    bits = {wnr, a, d};
    for (int i = 0; i < nbits; i++) begin
      SCI_CSN = 1'b0;
      SCI_SIN = bits[37-i];
      @(negedge CLK);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    int we0;
    we0 = we_cnt;
    wr_q.push_back('{addr: a, data: d});
    drive_frame(1'b1, a, d, 38);
    SCI_SIN = 1'($urandom);
    total++;
    if (REG_WE !== 1'b1 || SCI_SACK !== FLOAT || SCI_SOUT !== FLOAT) begin
      bad++;
      $display("FAIL wr_strobe got we=%b sack=%b sout=%b want we=1 sack=Z sout=Z", REG_WE, SCI_SACK, SCI_SOUT);
    end
    @(negedge CLK);
    total++;
    if (SCI_SACK !== 1'b1 || SCI_SOUT !== 1'b0 || REG_WE !== 1'b0) begin
      bad++;
      $display("FAIL wr_ack got sack=%b sout=%b we=%b want sack=1 sout=0 we=0", SCI_SACK, SCI_SOUT, REG_WE);
    end
    @(negedge CLK);
    total++;
    if (SCI_SACK !== FLOAT || SCI_SOUT !== FLOAT) begin
      bad++;
      $display("FAIL wr_done got sack=%b sout=%b want Z Z", SCI_SACK, SCI_SOUT);
    end
    SCI_CSN = 1'b1;
    @(negedge CLK);
    total++;
    if (we_cnt !== we0 + 1 || wr_q.size() != 0) begin
      bad++;
      $display("FAIL wr_count got strobes=%0d pending=%0d want strobes=%0d pending=0", we_cnt - we0, wr_q.size(), 1);
    end
  endtask

  task automatic do_read(input logic [4:0] a, input logic [31:0] expect_d);
    logic [31:0] got;
    logic [31:0] want;
    int sack_err;
    int re0;
    re0 = re_cnt;
    sack_err = 0;
    rd_q.push_back(expect_d);
    drive_frame(1'b0, a, 32'h0, 6);
    total++;
    if (REG_RE !== 1'b1 || REG_WE !== 1'b0 || REG_ADDR !== a) begin
      bad++;
      $display("FAIL rd_strobe got re=%b we=%b addr=%h want re=1 we=0 addr=%h", REG_RE, REG_WE, REG_ADDR, a);
    end
    @(negedge CLK);
    total++;
    if (REG_RE !== 1'b0 || SCI_SACK !== FLOAT || SCI_SOUT !== FLOAT) begin
      bad++;
      $display("FAIL rd_capture got re=%b sack=%b sout=%b want re=0 sack=Z sout=Z", REG_RE, SCI_SACK, SCI_SOUT);
    end
    @(negedge CLK);
    total++;
    if (SCI_SACK !== 1'b1 || SCI_SOUT !== 1'b0) begin
      bad++;
      $display("FAIL rd_ack got sack=%b sout=%b want sack=1 sout=0", SCI_SACK, SCI_SOUT);
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge CLK);
      got[31-i] = SCI_SOUT;
      if (SCI_SACK !== 1'b0) sack_err++;
    end
    want = rd_q.pop_front();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL rd_data got=%h want=%h", got, want);
    end
    total++;
    if (sack_err != 0) begin
      bad++;
      $display("FAIL rd_tx_sack got %0d cycles not driven low want 0", sack_err);
    end
    @(negedge CLK);
    total++;
    if (SCI_SACK !== FLOAT || SCI_SOUT !== FLOAT || re_cnt !== re0 + 1) begin
      bad++;
      $display("FAIL rd_done got sack=%b sout=%b strobes=%0d want Z Z 1", SCI_SACK, SCI_SOUT, re_cnt - re0);
    end
    SCI_CSN = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset;
    RSTN = 1'b0;
    SCI_CSN = 1'b0;
    SCI_SIN = 1'b1;
    repeat (3) @(negedge CLK);
    total++;
    if (REG_WE !== 1'b0 || REG_RE !== 1'b0 || REG_ADDR !== 5'h0 || REG_WDATA !== 32'h0 ||
        SCI_SOUT !== FLOAT || SCI_SACK !== FLOAT) begin
      bad++;
      $display("FAIL reset got we=%b re=%b addr=%h wdata=%h sout=%b sack=%b want 0 0 00 00000000 Z Z",
               REG_WE, REG_RE, REG_ADDR, REG_WDATA, SCI_SOUT, SCI_SACK);
    end
    SCI_CSN = 1'b1;
    RSTN = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_write;
    do_write(5'h0A, 32'hDEADBEEF);
    repeat (3) @(negedge CLK);
    total++;
    if (REG_ADDR !== 5'h0A || REG_WDATA !== 32'hDEADBEEF || re_cnt != 0) begin
      bad++;
      $display("FAIL write_hold got addr=%h wdata=%h reads=%0d want 0a deadbeef 0", REG_ADDR, REG_WDATA, re_cnt);
    end
  endtask

  task automatic test_read;
    bank[5'h13] = 32'hA5A50F0F;
    do_read(5'h13, 32'hA5A50F0F);
  endtask

  task automatic test_abort;
    int we0;
    we0 = we_cnt;
    drive_frame(1'b1, 5'h0C, 32'h12345678, 16);
    SCI_CSN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      total++;
      if (REG_WE !== 1'b0 || SCI_SACK !== FLOAT || SCI_SOUT !== FLOAT) begin
        bad++;
        $display("FAIL abort_quiet got we=%b sack=%b sout=%b want 0 Z Z", REG_WE, SCI_SACK, SCI_SOUT);
      end
    end
    total++;
    if (REG_ADDR !== 5'h13 || we_cnt != we0) begin
      bad++;
      $display("FAIL abort_addr got addr=%h strobes=%0d want addr=13 strobes=0", REG_ADDR, we_cnt - we0);
    end
    do_write(5'h01, 32'hCAFEF00D);
  endtask

  task automatic test_reset_mid_read;
    bank[5'h07] = 32'h0F0F1234;
    drive_frame(1'b0, 5'h07, 32'h0, 6);
    repeat (7) @(negedge CLK);
    total++;
    if (SCI_SACK !== 1'b0) begin
      bad++;
      $display("FAIL mid_tx got sack=%b want 0", SCI_SACK);
    end
    RSTN = 1'b0;
    @(negedge CLK);
    total++;
    if (SCI_SOUT !== FLOAT || SCI_SACK !== FLOAT || REG_WE !== 1'b0 || REG_RE !== 1'b0 ||
        REG_ADDR !== 5'h0 || REG_WDATA !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_read got sout=%b sack=%b we=%b re=%b addr=%h wdata=%h want Z Z 0 0 00 00000000",
               SCI_SOUT, SCI_SACK, REG_WE, REG_RE, REG_ADDR, REG_WDATA);
    end
    RSTN = 1'b1;
    do_write(5'h05, 32'h13579BDF);
  endtask

  task automatic test_idle;
    int we0;
    int re0;
    we0 = we_cnt;
    re0 = re_cnt;
    SCI_CSN = 1'b1;
    for (int i = 0; i < 100; i++) begin
      SCI_SIN = 1'($urandom);
      @(negedge CLK);
      total++;
      if (REG_WE !== 1'b0 || REG_RE !== 1'b0 || SCI_SOUT !== FLOAT || SCI_SACK !== FLOAT) begin
        bad++;
        $display("FAIL idle_bus cycle=%0d got we=%b re=%b sout=%b sack=%b want 0 0 Z Z",
                 i, REG_WE, REG_RE, SCI_SOUT, SCI_SACK);
      end
    end
    total++;
    if (we_cnt != we0 || re_cnt != re0) begin
      bad++;
      $display("FAIL idle_strobes got we=%0d re=%0d want 0 0", we_cnt - we0, re_cnt - re0);
    end
  endtask

  task automatic test_back_to_back;
    do_write(5'h1F, 32'h00000001);
    do_read(5'h1F, 32'h00000001);
  endtask

  initial begin
    RSTN = 1'b0;
    SCI_CSN = 1'b1;
    SCI_SIN = 1'b0;
    REG_RDATA = 32'h0;
    for (int i = 0; i < 32; i++) bank[i] = 32'h0;
    @(negedge CLK);
    test_reset;
    test_write;
    test_read;
    test_abort;
    test_reset_mid_read;
    test_idle;
    test_back_to_back;
    repeat (2) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
